ps2_keyboard_rx: RTL and testbench
==================================

// Module: ps2_keyboard_rx
//
// PURPOSE
//  Receive-only PS/2 keyboard front end feeding the ZX48 key matrix and the top-level hotkey decoder (F5/F12/Ctrl/Alt/Del/ScrLk).
//  Samples the PS/2 clock and data lines on a clock-enable tick, deframes 11-bit frames and folds the E0/F0 prefixes.
//  Emits one strobe per complete scancode together with make/break and extended flags.
//
// PARAMETERS
//  FILTER   4     consecutive equal ce-samples needed before a line level is accepted
//  TIMEOUT  7000  ce ticks (~1 ms at 7 MHz) without a falling ps2Ck edge mid-frame before the frame is aborted
//
// PORTS
//  clock   in     1  system clock (56 MHz)
//  reset   in     1  asynchronous, active-low reset
//  ce      in     1  sample enable (7 MHz tick); all state advances only when ce=1
//  ps2Ck   inout  1  PS/2 clock; never driven (constant Z), read only
//  ps2DQ   inout  1  PS/2 data; never driven (constant Z), read only
//  kstb    out    1  one-clock pulse: code/make/ext valid
//  make    out    1  0 = key pressed, 1 = key released (F0 seen)
//  code    out    8  scancode byte without prefixes
//  ext     out    1  1 = code was preceded by E0
//  perr    out    1  one-clock pulse: parity, start or stop error, or timeout
//
// BEHAVIOUR
//  - Reset values: kstb=0, make=1, code=8'h00, ext=0, perr=0, FSM=IDLE, prefix flags clear, filtered lines=1.
//  - Line path: 2-flop synchroniser, then a FILTER-deep filter; the filtered level changes only after FILTER equal samples on ce.
//  - Falling edge = filtered ps2Ck 1->0 on a ce tick; ps2DQ is sampled on that same tick.
//  - FSM states and transitions (on falling edge only):
//    * IDLE: DQ=0 -> DATA (bit count 0); DQ=1 -> perr pulse, stay IDLE.
//    * DATA: shift DQ in LSB-first; after the 8th bit -> PARITY.
//    * PARITY: store DQ -> STOP.
//    * STOP: accept the byte if DQ=1 and the 9-bit data+parity has odd weight; otherwise perr pulse, clear prefixes. Always -> IDLE.
//  - Timeout: a counter runs on ce in any state except IDLE and restarts at every falling edge.
//    At TIMEOUT -> IDLE, perr pulse, prefixes cleared, partial byte discarded.
//  - Accepted byte handling:
//    * E0: set ext_pend, no strobe.
//    * F0: set brk_pend, no strobe.
//    * E1: discarded, no strobe, pending flags unchanged.
//    * Any other byte: kstb=1 for one clock, code=byte, make=brk_pend, ext=ext_pend, then clear both pending flags.
//  - Latency: kstb and perr assert on the clock edge of the ce tick at which the stop bit is sampled.
//    Both return to 0 on the next clock. code/make/ext hold until the next strobe.
//  - Prefix order is free: E0 F0 xx and F0 E0 xx both give ext=1, make=1.
//  - Reset may assert mid-frame: everything returns to reset values immediately, with no strobe.
//    A frame already in flight is then caught by the start-bit check or the timeout.
//  - ce=0 freezes all state, including the timeout counter. A ps2Ck glitch shorter than FILTER ce ticks is ignored.
//
// STRUCTURE
//  - Package zx48_ps2_pkg: state enum {IDLE, DATA, PARITY, STOP}; localparams PFX_EXT=8'hE0, PFX_BRK=8'hF0, PFX_PAUSE=8'hE1.
//  - Sub-module ps2_line_filter (synchroniser + FILTER-deep filter, parameter FILTER), instantiated for ps2Ck and ps2DQ.
//  - Top body: edge detect, FSM, shift register, parity, timeout counter, prefix flags, output registers.
//
// TESTING
//  - Frame 8'h1C, odd parity, 10 kHz bit rate -> one kstb with code=8'h1C, make=0, ext=0; perr never asserts.
//  - Frames F0,1C -> exactly one kstb, with code=8'h1C, make=1, ext=0.
//  - Frames E0,F0,75, then 75 -> kstb(75, make=1, ext=1) followed by kstb(75, make=0, ext=0).
//  - Frame 8'h07 with wrong parity -> perr pulse, no kstb; a following good frame 8'h07 gives kstb, make=0.
//  - Stop after 4 data bits for 1200 ce ticks, then send 8'h71 -> perr at tick 7000, then kstb code=8'h71.
//  - Assert reset for 3 clocks mid-DATA, then send 8'h11 -> outputs at reset values, no spurious kstb, then clean kstb code=8'h11.
//  - A 2-tick ps2Ck low glitch in IDLE -> no state change, no perr.

Source files
------------

// File: rtl/zx48_ps2_pkg.sv
// ============================================================================
// zx48_ps2_pkg : shared types and constants for the PS/2 keyboard receiver
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

package zx48_ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  // Weight check over data+parity; a valid PS/2 frame has odd weight.
  function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
    return ^{par, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// ============================================================================
// ps2_line_filter : 2-flop synchroniser followed by a FILTER-deep level filter
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_line_filter #(
  parameter int FILTER = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic din,
  output logic dout
);

  import zx48_ps2_pkg::*;

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q,  filt_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  // The filtered level flips only after FILTER consecutive differing samples.
  always_comb begin
    sync1_d = sync1_q;
    sync2_d = sync2_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    if (ce) begin
      sync1_d = din;
      sync2_d = sync1_q;
      if (sync2_q == filt_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(FILTER - 1)) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign dout = filt_q;

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
// ============================================================================
// ps2_keyboard_rx : receive-only PS/2 keyboard deframer with E0/F0 prefix folding
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_keyboard_rx #(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 7000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  inout  wire        ps2Ck,
  inout  wire        ps2DQ,
  output logic       kstb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       perr
);

  import zx48_ps2_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic ck_f;
  logic dq_f;
  logic fall;

  ps2_state_e    state_q,    state_d;
  logic [2:0]    bit_cnt_q,  bit_cnt_d;
  logic [7:0]    shift_q,    shift_d;
  logic          par_q,      par_d;
  logic [TW-1:0] tmo_q,      tmo_d;
  logic          ck_prev_q,  ck_prev_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic          kstb_q,     kstb_d;
  logic          make_q,     make_d;
  logic [7:0]    code_q,     code_d;
  logic          ext_q,      ext_d;
  logic          perr_q,     perr_d;

  ps2_line_filter #(.FILTER(FILTER)) u_ck_filter (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .din   (ps2Ck),
    .dout  (ck_f)
  );

  ps2_line_filter #(.FILTER(FILTER)) u_dq_filter (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .din   (ps2DQ),
    .dout  (dq_f)
  );

  assign fall = ce && ck_prev_q && !ck_f;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      ck_prev_q  <= 1'b1;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      kstb_q     <= 1'b0;
      make_q     <= 1'b1;
      code_q     <= 8'h00;
      ext_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      ck_prev_q  <= ck_prev_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      kstb_q     <= kstb_d;
      make_q     <= make_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      perr_q     <= perr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmo_d      = tmo_q;
    ck_prev_d  = ck_prev_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    kstb_d     = 1'b0;
    make_d     = make_q;
    code_d     = code_q;
    ext_d      = ext_q;
    perr_d     = 1'b0;

    if (ce) begin
      ck_prev_d = ck_f;

      if (state_q == IDLE || fall) begin
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end

      // A stalled frame is abandoned wholesale, prefixes included.
      if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT - 1)) begin
        state_d    = IDLE;
        tmo_d      = '0;
        perr_d     = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end else if (fall) begin
        unique case (state_q)
          IDLE: begin
            if (!dq_f) begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end else begin
              perr_d = 1'b1;
            end
          end
          DATA: begin
            shift_d = {dq_f, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_d = PARITY;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
          PARITY: begin
            par_d   = dq_f;
            state_d = STOP;
          end
          STOP: begin
            state_d = IDLE;
            if (dq_f && frame_parity_ok(shift_q, par_q)) begin
              if (shift_q == PFX_EXT) begin
                ext_pend_d = 1'b1;
              end else if (shift_q == PFX_BRK) begin
                brk_pend_d = 1'b1;
              end else if (shift_q != PFX_PAUSE) begin
                kstb_d     = 1'b1;
                code_d     = shift_q;
                make_d     = brk_pend_q;
                ext_d      = ext_pend_q;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
              end
            end else begin
              perr_d     = 1'b1;
              ext_pend_d = 1'b0;
              brk_pend_d = 1'b0;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign kstb = kstb_q;
  assign make = make_q;
  assign code = code_q;
  assign ext  = ext_q;
  assign perr = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
// ============================================================================
// tb_ps2_keyboard_rx : directed self-checking bench for ps2_keyboard_rx
// Revision           : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_keyboard_rx;

  localparam int HALF = 20;

  logic       clock  = 1'b0;
  logic       reset  = 1'b0;
  logic       ce     = 1'b0;
  logic       ck_drv = 1'b1;
  logic       dq_drv = 1'b1;
  wire        ps2_ck = ck_drv;
  wire        ps2_dq = dq_drv;
  logic       kstb;
  logic       make;
  logic [7:0] code;
  logic       ext;
  logic       perr;

  int tests = 0;
  int fails = 0;
  int kcnt  = 0;
  int pcnt  = 0;
  int k0;
  int p0;

  ps2_keyboard_rx #(.FILTER(4), .TIMEOUT(7000)) dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .ps2Ck (ps2_ck),
    .ps2DQ (ps2_dq),
    .kstb  (kstb),
    .make  (make),
    .code  (code),
    .ext   (ext),
    .perr  (perr)
  );

  always #5 clock = ~clock;

  // ce is high every other clock
  initial begin
    forever begin
      @(negedge clock);
      ce = ~ce;
    end
  end

  always @(posedge clock) begin
    #1;
    if (kstb === 1'b1) kcnt = kcnt + 1;
    if (perr === 1'b1) pcnt = pcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ce(input int n);
    repeat (2 * n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    dq_drv = b;
    wait_ce(HALF);
    ck_drv = 1'b0;
    wait_ce(HALF);
    ck_drv = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    logic p;
    p = (~^d) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(1'b1);
    dq_drv = 1'b1;
    wait_ce(2 * HALF);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    dq_drv = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("rst_kstb", {31'd0, kstb}, 32'd0);
    chk("rst_make", {31'd0, make}, 32'd1);
    chk("rst_code", {24'd0, code}, 32'h00);
    chk("rst_ext",  {31'd0, ext},  32'd0);
    chk("rst_perr", {31'd0, perr}, 32'd0);
    reset = 1'b1;
    wait_ce(20);

    // plain make code
    k0 = kcnt; p0 = pcnt;
    send_frame(8'h1C, 1'b0);
    chk("make1c_cnt",  kcnt - k0, 32'd1);
    chk("make1c_code", {24'd0, code}, 32'h1C);
    chk("make1c_make", {31'd0, make}, 32'd0);
    chk("make1c_ext",  {31'd0, ext},  32'd0);
    chk("make1c_perr", pcnt - p0, 32'd0);

    // break code
    k0 = kcnt;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk("brk1c_cnt",  kcnt - k0, 32'd1);
    chk("brk1c_code", {24'd0, code}, 32'h1C);
    chk("brk1c_make", {31'd0, make}, 32'd1);
    chk("brk1c_ext",  {31'd0, ext},  32'd0);

    // extended break, then plain make of the same code
    k0 = kcnt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk("ebrk75_cnt",  kcnt - k0, 32'd1);
    chk("ebrk75_code", {24'd0, code}, 32'h75);
    chk("ebrk75_mk",   {31'd0, make, 31'd0} >> 31, 32'd1);
    chk("ebrk75_ext",  {31'd0, ext},  32'd1);
    send_frame(8'h75, 1'b0);
    chk("mk75_cnt",  kcnt - k0, 32'd2);
    chk("mk75_make", {31'd0, make}, 32'd0);
    chk("mk75_ext",  {31'd0, ext},  32'd0);

    // reversed prefix order, E1 discarded without touching pending flags
    k0 = kcnt;
    send_frame(8'hF0, 1'b0);
    send_frame(8'hE1, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h6B, 1'b0);
    chk("rev6b_cnt",  kcnt - k0, 32'd1);
    chk("rev6b_code", {24'd0, code}, 32'h6B);
    chk("rev6b_make", {31'd0, make}, 32'd1);
    chk("rev6b_ext",  {31'd0, ext},  32'd1);

    // parity error with a pending break that must be dropped
    k0 = kcnt; p0 = pcnt;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h07, 1'b1);
    chk("par07_perr", pcnt - p0, 32'd1);
    chk("par07_kstb", kcnt - k0, 32'd0);
    send_frame(8'h07, 1'b0);
    chk("good07_cnt",  kcnt - k0, 32'd1);
    chk("good07_code", {24'd0, code}, 32'h07);
    chk("good07_make", {31'd0, make}, 32'd0);

    // stall mid-frame until the timeout fires
    k0 = kcnt;
    send_frame(8'hF0, 1'b0);
    p0 = pcnt;
    send_partial(8'h71, 4);
    wait_ce(1200);
    chk("tmo_1200", pcnt - p0, 32'd0);
    wait_ce(5700);
    chk("tmo_6920", pcnt - p0, 32'd0);
    wait_ce(200);
    chk("tmo_7120", pcnt - p0, 32'd1);
    chk("tmo_kstb", kcnt - k0, 32'd0);
    wait_ce(2 * HALF);
    send_frame(8'h71, 1'b0);
    chk("post_tmo_cnt",  kcnt - k0, 32'd1);
    chk("post_tmo_code", {24'd0, code}, 32'h71);
    chk("post_tmo_make", {31'd0, make}, 32'd0);

    // asynchronous reset mid-DATA with an extended prefix pending
    send_frame(8'hE0, 1'b0);
    k0 = kcnt;
    send_partial(8'h33, 3);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("mrst_kstb", {31'd0, kstb}, 32'd0);
    chk("mrst_make", {31'd0, make}, 32'd1);
    chk("mrst_code", {24'd0, code}, 32'h00);
    chk("mrst_ext",  {31'd0, ext},  32'd0);
    reset = 1'b1;
    wait_ce(2 * HALF);
    chk("mrst_nostb", kcnt - k0, 32'd0);
    send_frame(8'h11, 1'b0);
    chk("mrst11_cnt",  kcnt - k0, 32'd1);
    chk("mrst11_code", {24'd0, code}, 32'h11);
    chk("mrst11_make", {31'd0, make}, 32'd0);
    chk("mrst11_ext",  {31'd0, ext},  32'd0);

    // short clock glitch in IDLE must be ignored
    k0 = kcnt; p0 = pcnt;
    ck_drv = 1'b0;
    wait_ce(2);
    ck_drv = 1'b1;
    wait_ce(2 * HALF);
    chk("glitch_perr", pcnt - p0, 32'd0);
    chk("glitch_kstb", kcnt - k0, 32'd0);
    send_frame(8'h5A, 1'b0);
    chk("glitch5a_cnt",  kcnt - k0, 32'd1);
    chk("glitch5a_code", {24'd0, code}, 32'h5A);
    chk("glitch5a_perr", pcnt - p0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
